bch_error_dec_ctrl: RTL and testbench
=====================================

// Module: bch_error_dec_ctrl
// PURPOSE
//  Frame sequencer for bch_error_dec. Accepts one syndrome set per codeword via valid/ready, issues the
//  decoder start pulse, waits for the decoder's first output and streams BITS error-location bits per cycle
//  for exactly DATA_BITS bits. Tags each frame with first/last and a latched error count.
//  Flags uncorrectable frames and decoder timeouts. Sits between the syndrome unit and the XOR-correction stage.
// PARAMETERS
//  P          `BCH_SANE  BCH code parameter word (M, T derived via `BCH_M/`BCH_T)
//  BITS       1          error bits per cycle; must match the bch_error_dec instance
//  DATA_BITS  `BCH_DATA_BITS(P)  bits per frame to stream; BEATS = ceil(DATA_BITS/BITS)
//  MAX_LAT    16         max cycles from dec_start to dec_first before timeout
// PORTS
//  clk            in   1                        clock, all logic rising-edge
//  reset          in   1                        synchronous, active-high
//  syn_valid      in   1                        syndrome set available
//  syn_ready      out  1                        controller can accept syndromes this cycle
//  syndromes      in   `BCH_SYNDROMES_SZ(P)     syndrome set, sampled when syn_valid&&syn_ready
//  dec_start      out  1                        one-cycle start pulse to decoder
//  dec_syndromes  out  `BCH_SYNDROMES_SZ(P)     registered syndromes, stable from dec_start until next accept
//  dec_first      in   1                        decoder first-valid-output strobe
//  dec_err        in   BITS                     decoder error-location bits
//  dec_err_count  in   `BCH_ERR_SZ(P)           decoder error count, valid on dec_first
//  err_valid      out  1                        err/err_first/err_last valid
//  err            out  BITS                     error-location bits, padding bits of last beat forced 0
//  err_first      out  1                        first beat of frame
//  err_last       out  1                        last beat of frame
//  err_count      out  `BCH_ERR_SZ(P)           count latched at dec_first, held until next dec_first
//  uncorrectable  out  1                        err_count > T, held with err_count
//  timeout        out  1                        one-cycle pulse: dec_first missing for MAX_LAT cycles
// BEHAVIOUR
//  Reset: state=IDLE; syn_ready=0 during reset, 1 the cycle after; all other outputs 0; dec_syndromes=0.
//  FSM IDLE: syn_ready=1. Accept -> capture syndromes, dec_start=1 next cycle (registered), go WAIT.
//  FSM WAIT: syn_ready=0; lat_cnt counts from 0 each cycle. dec_first -> go STREAM, beat=0, output beat 0
//   the same cycle (err_valid=err_first=1, err=dec_err combinationally masked), latch err_count/uncorrectable.
//   lat_cnt reaches MAX_LAT-1 without dec_first -> timeout pulse, go IDLE; no err_valid for that frame.
//  FSM STREAM: err_valid=1 every cycle, beat increments by 1; beat==BEATS-1 -> err_last=1.
//   syn_ready=1 only on the last beat; accept there -> dec_start next cycle, go WAIT (back-to-back frames,
//   no idle bubble besides decoder latency); otherwise go IDLE.
//  BEATS==1: err_first and err_last both 1 on the single beat.
//  Last-beat mask: bits [BITS-1 : DATA_BITS-(BEATS-1)*BITS] zeroed when DATA_BITS%BITS!=0.
//  dec_first seen in IDLE or STREAM: ignored (no state change, no output).
//  beat counter width clog2(BEATS); lat_cnt width clog2(MAX_LAT); no wrap possible in legal flow.
//  reset asserted mid-frame: next cycle state=IDLE, in-flight frame dropped, no err_last emitted.
//  Simultaneous syn_valid with reset: not accepted.
// TESTING
//  Single frame, DATA_BITS=16, BITS=4, T=2, 2 errors -> dec_start 1 cycle after accept; 4 beats err_valid,
//   err_first on beat0, err_last on beat3, err_count=2, uncorrectable=0.
//  Back-to-back: syn_valid held high across 3 frames -> accept only on IDLE and each last beat; 3x4 beats, each
//   frame's err_count matches its own dec_first value.
//  Partial beat: DATA_BITS=10, BITS=4, dec_err=4'b1111 every beat -> beat2 err=4'b0011, err_last=1.
//  Uncorrectable: dec_err_count=3 with T=2 -> uncorrectable=1 for whole frame, frame still streamed.
//  Timeout: MAX_LAT=16, dec_first never asserted -> timeout pulse exactly 16 cycles after dec_start, IDLE next,
//   syn_ready=1.
//  Reset on beat 1 of 4 -> err_valid=0 next cycle, no err_last, all outputs 0, next frame decodes normally.

Source files
------------

// File: rtl/bch_error_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bch_error_dec_ctrl
// Purpose  : Frame sequencer around bch_error_dec. It hands one syndrome set
//            per codeword to the decoder and streams the framed error bits on.
// Revision : 1.0 - initial release
// ============================================================================
module bch_error_dec_ctrl #(
    parameter int M         = 5,
    parameter int T         = 2,
    parameter int SYN_W     = 2 * T * M,
    parameter int ERR_W     = $clog2(T + 2),
    parameter int BITS      = 1,
    parameter int DATA_BITS = 16,
    parameter int MAX_LAT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             syn_valid,
    output logic             syn_ready,
    input  logic [SYN_W-1:0] syndromes,
    output logic             dec_start,
    output logic [SYN_W-1:0] dec_syndromes,
    input  logic             dec_first,
    input  logic [BITS-1:0]  dec_err,
    input  logic [ERR_W-1:0] dec_err_count,
    output logic             err_valid,
    output logic [BITS-1:0]  err,
    output logic             err_first,
    output logic             err_last,
    output logic [ERR_W-1:0] err_count,
    output logic             uncorrectable,
    output logic             timeout
);

    localparam int c_BEATS     = (DATA_BITS + BITS - 1) / BITS;
    localparam int c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_LAT_W     = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int c_LAST_BITS = DATA_BITS - (c_BEATS - 1) * BITS;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_LAT_W-1:0]  c_LAT_LAST  = c_LAT_W'(MAX_LAT - 1);
    localparam logic [BITS-1:0]     c_LAST_MASK = {BITS{1'b1}} >> (BITS - c_LAST_BITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_LAT_W-1:0]  r_lat_cnt;
    logic               r_dec_start;
    logic [SYN_W-1:0]   r_dec_syndromes;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_uncorr;
    logic               r_timeout;

    logic w_fire;
    logic w_last_beat;
    logic w_ready;
    logic w_accept;
    logic w_lat_expired;
    logic w_uncorr_in;

    // Beat 0 is emitted straight from the decoder strobe while still in WAIT.
    assign w_fire        = (r_state == S_WAIT) && dec_first;
    assign w_last_beat   = ((r_state == S_STREAM) && (r_beat == c_LAST_BEAT)) ||
                           (w_fire && (c_BEATS == 1));
    assign w_ready       = !reset && ((r_state == S_IDLE) || w_last_beat);
    assign w_accept      = syn_valid && w_ready;
    assign w_lat_expired = (r_state == S_WAIT) && !dec_first && (r_lat_cnt == c_LAT_LAST);
    assign w_uncorr_in   = (dec_err_count > ERR_W'(T));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_beat          <= '0;
            r_lat_cnt       <= '0;
            r_dec_start     <= 1'b0;
            r_dec_syndromes <= '0;
            r_err_count     <= '0;
            r_uncorr        <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_dec_start <= w_accept;
            r_timeout   <= w_lat_expired;
            if (w_accept) begin
                r_dec_syndromes <= syndromes;
            end
            if ((r_state == S_WAIT) && !w_accept) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end else begin
                r_lat_cnt <= '0;
            end
            if (w_fire) begin
                r_beat      <= c_BEAT_W'(1);
                r_err_count <= dec_err_count;
                r_uncorr    <= w_uncorr_in;
            end else if (r_state == S_STREAM) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        syn_ready     = w_ready;
        dec_start     = r_dec_start;
        dec_syndromes = r_dec_syndromes;
        timeout       = r_timeout;
        err_valid     = w_fire || (r_state == S_STREAM);
        err_first     = w_fire;
        err_last      = w_last_beat;
        err           = '0;
        // Count and flag bypass the latch on the strobe cycle so beat 0 is tagged too.
        err_count     = w_fire ? dec_err_count : r_err_count;
        uncorrectable = w_fire ? w_uncorr_in : r_uncorr;

        if (err_valid) begin
            err = w_last_beat ? (dec_err & c_LAST_MASK) : dec_err;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dec_first) begin
                    if (c_BEATS == 1) begin
                        w_next_state = w_accept ? S_WAIT : S_IDLE;
                    end else begin
                        w_next_state = S_STREAM;
                    end
                end else if (w_lat_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            S_STREAM: begin
                if (w_last_beat) begin
                    w_next_state = w_accept ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_error_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_error_dec_ctrl
// Purpose  : Self-checking bench for bch_error_dec_ctrl with a decoder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_error_dec_ctrl;

    localparam int T         = 2;
    localparam int M         = 5;
    localparam int SYN_W     = 2 * T * M;
    localparam int ERR_W     = $clog2(T + 2);
    localparam int BITS      = 4;
    localparam int DATA_BITS = 16;
    localparam int BEATS     = 4;
    localparam int MAX_LAT   = 16;

    typedef struct {
        logic [BITS-1:0]  err;
        logic             first;
        logic             last;
        logic [ERR_W-1:0] cnt;
        logic             unc;
    } beat_t;

    typedef struct {
        int lat;
        int cnt;
        int nbeats;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             syn_valid, syn_ready, dec_start, dec_first;
    logic [SYN_W-1:0] syndromes, dec_syndromes;
    logic [BITS-1:0]  dec_err, err;
    logic [ERR_W-1:0] dec_err_count, err_count;
    logic             err_valid, err_first, err_last, uncorrectable, timeout;

    logic             syn_valid2, syn_ready2, dec_start2, dec_first2;
    logic [SYN_W-1:0] syndromes2, dec_syndromes2;
    logic [BITS-1:0]  dec_err2, err2;
    logic [ERR_W-1:0] dec_err_count2, err_count2;
    logic             err_valid2, err_first2, err_last2, uncorrectable2, timeout2;

    bch_error_dec_ctrl #(
        .M(M), .T(T), .SYN_W(SYN_W), .ERR_W(ERR_W),
        .BITS(BITS), .DATA_BITS(DATA_BITS), .MAX_LAT(MAX_LAT)
    ) u_dut (
        .clk(clk), .reset(reset),
        .syn_valid(syn_valid), .syn_ready(syn_ready), .syndromes(syndromes),
        .dec_start(dec_start), .dec_syndromes(dec_syndromes),
        .dec_first(dec_first), .dec_err(dec_err), .dec_err_count(dec_err_count),
        .err_valid(err_valid), .err(err), .err_first(err_first), .err_last(err_last),
        .err_count(err_count), .uncorrectable(uncorrectable), .timeout(timeout)
    );

    // Partial last beat instance: 10 bits in 4-bit beats.
    bch_error_dec_ctrl #(
        .M(M), .T(T), .SYN_W(SYN_W), .ERR_W(ERR_W),
        .BITS(BITS), .DATA_BITS(10), .MAX_LAT(MAX_LAT)
    ) u_dut_part (
        .clk(clk), .reset(reset),
        .syn_valid(syn_valid2), .syn_ready(syn_ready2), .syndromes(syndromes2),
        .dec_start(dec_start2), .dec_syndromes(dec_syndromes2),
        .dec_first(dec_first2), .dec_err(dec_err2), .dec_err_count(dec_err_count2),
        .err_valid(err_valid2), .err(err2), .err_first(err_first2), .err_last(err_last2),
        .err_count(err_count2), .uncorrectable(uncorrectable2), .timeout(timeout2)
    );

    beat_t            sb_q[$];
    frame_t           fr_q[$];
    logic [SYN_W-1:0] syn_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_beats  = 0;
    logic             model_busy = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decoder model: answers each dec_start after fr.lat cycles; lat 0 never answers.
    task automatic dec_model();
        frame_t fr;
        beat_t  e;
        forever begin
            step();
            while (dec_start && fr_q.size() > 0) begin
                fr = fr_q.pop_front();
                if (fr.lat == 0) break;
                model_busy = 1'b1;
                repeat (fr.lat) step();
                for (int b = 0; b < BEATS; b++) begin
                    dec_first     = (b == 0);
                    dec_err       = BITS'($urandom);
                    dec_err_count = (b == 0) ? ERR_W'(fr.cnt) : ERR_W'($urandom);
                    if (b < fr.nbeats) begin
                        e.err   = dec_err;
                        e.first = (b == 0);
                        e.last  = (b == BEATS - 1);
                        e.cnt   = ERR_W'(fr.cnt);
                        e.unc   = (fr.cnt > T);
                        sb_q.push_back(e);
                    end
                    step();
                end
                dec_first  = 1'b0;
                dec_err    = '0;
                model_busy = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        beat_t            e;
        logic [SYN_W-1:0] s;
        forever begin
            @(negedge clk);
            if (dec_start === 1'b1) begin
                n_checks++;
                if (syn_q.size() == 0) begin
                    $display("FAIL dec_start_unexpected: got dec_start=1 with no accepted syndromes, required 0");
                end else begin
                    s = syn_q.pop_front();
                    if (dec_syndromes !== s) $display("FAIL dec_syndromes: got %h, required %h", dec_syndromes, s);
                    else n_pass++;
                end
            end
            if (syn_valid === 1'b1 && syn_ready === 1'b1) syn_q.push_back(syndromes);
            if (err_valid === 1'b1) begin
                n_beats++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL beat_unexpected: got err_valid=1 err=%h, required err_valid=0", err);
                end else begin
                    e = sb_q.pop_front();
                    if (err !== e.err || err_first !== e.first || err_last !== e.last ||
                        err_count !== e.cnt || uncorrectable !== e.unc || syn_ready !== e.last)
                        $display("FAIL beat: got err=%h first=%b last=%b cnt=%0d unc=%b rdy=%b, required err=%h first=%b last=%b cnt=%0d unc=%b rdy=%b",
                                 err, err_first, err_last, err_count, uncorrectable, syn_ready,
                                 e.err, e.first, e.last, e.cnt, e.unc, e.last);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic send_frame();
        step();
        syn_valid = 1'b1;
        syndromes = SYN_W'($urandom);
        @(negedge clk);
        step();
        syn_valid = 1'b0;
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while ((model_busy || fr_q.size() != 0 || sb_q.size() != 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        syn_valid = 1'b1;
        syndromes = SYN_W'($urandom);
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (syn_ready !== 1'b0) $display("FAIL reset_syn_ready: got %b, required 0", syn_ready);
        else n_pass++;
        n_checks++;
        if ({dec_start, err_valid, err_first, err_last, err, err_count, uncorrectable, timeout} !== '0 ||
            dec_syndromes !== '0)
            $display("FAIL reset_outputs: got start=%b valid=%b first=%b last=%b err=%h cnt=%0d unc=%b to=%b syn=%h, required all 0",
                     dec_start, err_valid, err_first, err_last, err, err_count, uncorrectable, timeout, dec_syndromes);
        else n_pass++;
        step();
        reset     = 1'b0;
        syn_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (syn_ready !== 1'b1 || dec_start !== 1'b0)
            $display("FAIL reset_release: got syn_ready=%b dec_start=%b, required 1 0", syn_ready, dec_start);
        else n_pass++;
    endtask

    task automatic test_partial();
        step();
        syn_valid2 = 1'b1;
        syndromes2 = SYN_W'($urandom);
        step();
        syn_valid2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dec_start2 !== 1'b1) $display("FAIL part_dec_start: got %b, required 1", dec_start2);
        else n_pass++;
        step();
        dec_first2     = 1'b1;
        dec_err2       = 4'b1111;
        dec_err_count2 = ERR_W'(1);
        @(negedge clk);
        n_checks++;
        if ({err_valid2, err_first2, err_last2, err2} !== {3'b110, 4'b1111})
            $display("FAIL part_beat0: got v/f/l=%b%b%b err=%b, required 110 1111", err_valid2, err_first2, err_last2, err2);
        else n_pass++;
        step();
        dec_first2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({err_valid2, err_first2, err_last2, err2} !== {3'b100, 4'b1111})
            $display("FAIL part_beat1: got v/f/l=%b%b%b err=%b, required 100 1111", err_valid2, err_first2, err_last2, err2);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if ({err_valid2, err_first2, err_last2, err2} !== {3'b101, 4'b0011})
            $display("FAIL part_last_beat: got v/f/l=%b%b%b err=%b, required 101 0011", err_valid2, err_first2, err_last2, err2);
        else n_pass++;
        step();
        dec_err2 = '0;
        @(negedge clk);
        n_checks++;
        if (err_valid2 !== 1'b0 || err_count2 !== ERR_W'(1))
            $display("FAIL part_end: got err_valid=%b err_count=%0d, required 0 1", err_valid2, err_count2);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int b0, cyc;
        b0 = n_beats;
        fr_q.push_back('{3, 2, BEATS});
        step();
        syn_valid = 1'b1;
        syndromes = SYN_W'($urandom);
        @(negedge clk);
        n_checks++;
        if (syn_ready !== 1'b1) $display("FAIL sf_syn_ready: got %b, required 1", syn_ready);
        else n_pass++;
        step();
        syn_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dec_start !== 1'b1) $display("FAIL sf_dec_start: got %b, required 1", dec_start);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dec_start !== 1'b0 || syn_ready !== 1'b0)
            $display("FAIL sf_wait: got dec_start=%b syn_ready=%b, required 0 0", dec_start, syn_ready);
        else n_pass++;
        drain(cyc);
        n_checks++;
        if (n_beats - b0 !== BEATS || sb_q.size() != 0)
            $display("FAIL sf_beats: got %0d beats (%0d pending), required %0d", n_beats - b0, sb_q.size(), BEATS);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc, k, b0, cyc;
        acc = 0;
        k   = 0;
        b0  = n_beats;
        fr_q.push_back('{2, 1, BEATS});
        fr_q.push_back('{1, 3, BEATS});
        fr_q.push_back('{4, 0, BEATS});
        step();
        syn_valid = 1'b1;
        syndromes = SYN_W'($urandom);
        while (acc < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (syn_ready === 1'b1) acc++;
            step();
            syndromes = SYN_W'($urandom);
            if (acc == 3) syn_valid = 1'b0;
        end
        syn_valid = 1'b0;
        // Accepts land on cycle 1, then on each last beat: start + latency + BEATS-1 later.
        n_checks++;
        if (acc !== 3 || k !== 1 + (1 + 2 + BEATS - 1) + (1 + 1 + BEATS - 1))
            $display("FAIL b2b_accepts: got %0d accepts by cycle %0d, required 3 by cycle %0d",
                     acc, k, 1 + (1 + 2 + BEATS - 1) + (1 + 1 + BEATS - 1));
        else n_pass++;
        drain(cyc);
        n_checks++;
        if (n_beats - b0 !== 3 * BEATS || sb_q.size() != 0)
            $display("FAIL b2b_beats: got %0d beats (%0d pending), required %0d", n_beats - b0, sb_q.size(), 3 * BEATS);
        else n_pass++;
    endtask

    task automatic test_uncorrectable();
        int k, nu;
        k  = 0;
        nu = 0;
        fr_q.push_back('{2, 3, BEATS});
        send_frame();
        while ((model_busy || fr_q.size() != 0 || sb_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
            if (err_valid === 1'b1 && uncorrectable === 1'b1 && err_count === ERR_W'(3)) nu++;
        end
        n_checks++;
        if (nu !== BEATS) $display("FAIL uncorr_beats: got %0d flagged beats, required %0d", nu, BEATS);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        k = 0;
        fr_q.push_back('{0, 0, 0});
        send_frame();
        @(negedge clk);
        n_checks++;
        if (dec_start !== 1'b1) $display("FAIL to_dec_start: got %b, required 1", dec_start);
        else n_pass++;
        while (timeout !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== MAX_LAT) $display("FAIL to_latency: got %0d cycles, required %0d", k, MAX_LAT);
        else n_pass++;
        n_checks++;
        if (syn_ready !== 1'b1 || err_valid !== 1'b0)
            $display("FAIL to_idle: got syn_ready=%b err_valid=%b, required 1 0", syn_ready, err_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL to_pulse: got timeout=%b a cycle later, required 0", timeout);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k, b0, cyc;
        k = 0;
        fr_q.push_back('{2, 2, 2});
        send_frame();
        while (!(err_valid === 1'b1 && err_first === 1'b1) && k < 40) begin
            @(negedge clk);
            k++;
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({err_valid, err_last, err_first, err, err_count, uncorrectable, timeout, dec_start} !== '0 ||
            dec_syndromes !== '0 || syn_ready !== 1'b1)
            $display("FAIL rst_mid_outputs: got valid=%b last=%b cnt=%0d unc=%b to=%b start=%b syn=%h rdy=%b, required zeros and rdy=1",
                     err_valid, err_last, err_count, uncorrectable, timeout, dec_start, dec_syndromes, syn_ready);
        else n_pass++;
        drain(cyc);
        b0 = n_beats;
        fr_q.push_back('{1, 1, BEATS});
        send_frame();
        drain(cyc);
        n_checks++;
        if (n_beats - b0 !== BEATS || sb_q.size() != 0)
            $display("FAIL rst_mid_next: got %0d beats (%0d pending), required %0d", n_beats - b0, sb_q.size(), BEATS);
        else n_pass++;
    endtask

    initial begin
        reset          = 1'b1;
        syn_valid      = 1'b0;
        syndromes      = '0;
        dec_first      = 1'b0;
        dec_err        = '0;
        dec_err_count  = '0;
        syn_valid2     = 1'b0;
        syndromes2     = '0;
        dec_first2     = 1'b0;
        dec_err2       = '0;
        dec_err_count2 = '0;
        fork
            dec_model();
            monitor();
        join_none
        test_reset();
        test_partial();
        test_single_frame();
        test_back_to_back();
        test_uncorrectable();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
